// File: rtl/gpi_debounce.sv
// gpi_debounce
//   Input conditioner for the general-purpose input bus. Each raw pin level
//   goes through a two-flop synchroniser into the clk_sys_i domain. It is then
//   debounced independently: an output bit only follows its synchronised
//   input after StableTicks consecutive prescaler ticks of disagreement.
//
//   Ports
//     clk_sys_i  in          system clock (single domain)
//     rst_sys_i  in          synchronous, active-high reset
//     raw_i      in  [Width] asynchronous raw pin levels
//     gp_o       out [Width] debounced levels (registered)
//     rise_o     out [Width] one-cycle pulse coincident with a gp_o 0->1
//     fall_o     out [Width] one-cycle pulse coincident with a gp_o 1->0
//
//   Build option
//     GPI_DEBOUNCE_EDGE_EN  when defined, the rise/fall pulse registers are
//                           built; when undefined, rise_o/fall_o are tied to 0.

module gpi_debounce #(
    parameter int Width       = 15,
    parameter int TickDiv     = 100000,
    parameter int StableTicks = 8
) (
    input  logic             clk_sys_i,
    input  logic             rst_sys_i,
    input  logic [Width-1:0] raw_i,
    output logic [Width-1:0] gp_o,
    output logic [Width-1:0] rise_o,
    output logic [Width-1:0] fall_o
);

    localparam int PreW = (TickDiv > 1) ? $clog2(TickDiv) : 1;
    localparam int CntW = $clog2(StableTicks + 1);

    localparam logic [PreW-1:0] PreLast = PreW'(TickDiv - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(StableTicks - 1);

    logic [Width-1:0] s1_q;
    logic [Width-1:0] sync_q;
    logic [PreW-1:0]  pre_q;
    logic             tick;
    logic [CntW-1:0]  cnt_q [Width];
    logic [Width-1:0] gp_q;
    logic [Width-1:0] flip;

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            s1_q   <= '0;
            sync_q <= '0;
        end else begin
            s1_q   <= raw_i;
            sync_q <= s1_q;
        end
    end

    // With TickDiv == 1 the counter is a single bit stuck at 0, so tick is
    // permanently high.
    assign tick = (pre_q == PreLast);

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            pre_q <= '0;
        end else if (tick) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PreW'(1);
        end
    end

    // A bit flips on the tick that would bring its count to StableTicks, so
    // the counter itself never holds that value.
    always_comb begin
        flip = '0;
        for (int i = 0; i < Width; i++) begin
            flip[i] = tick && (sync_q[i] != gp_q[i]) && (cnt_q[i] == CntLast);
        end
    end

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            for (int i = 0; i < Width; i++) begin
                cnt_q[i] <= '0;
            end
            gp_q <= '0;
        end else begin
            for (int i = 0; i < Width; i++) begin
                // Any agreement, tick or not, restarts the stability count.
                if (sync_q[i] == gp_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (tick) begin
                    if (cnt_q[i] == CntLast) begin
                        cnt_q[i] <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + CntW'(1);
                    end
                end
            end
            gp_q <= gp_q ^ flip;
        end
    end

    assign gp_o = gp_q;

`ifdef GPI_DEBOUNCE_EDGE_EN
    logic [Width-1:0] rise_q;
    logic [Width-1:0] fall_q;

    // Registered from the same flip term that updates gp_q, so each pulse
    // lands in the cycle the new gp_o level first appears.
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= flip & sync_q;
            fall_q <= flip & ~sync_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
`else
    assign rise_o = '0;
    assign fall_o = '0;
`endif

endmodule
